// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio stream router.
package audio_pkg;

    // State table:
    //   ST_PASS      | selected source routed at full gain
    //   ST_RAMP_DOWN | gain falling one step per frame tick
    //   ST_SWAP      | single clk where the new source is latched
    //   ST_RAMP_UP   | gain rising one step per frame tick
    //   ST_MUTED     | gain held at zero, strobes still forwarded
    typedef enum logic [2:0] {
        ST_PASS      = 3'd0,
        ST_RAMP_DOWN = 3'd1,
        ST_SWAP      = 3'd2,
        ST_RAMP_UP   = 3'd3,
        ST_MUTED     = 3'd4
    } router_state_t;

    // Unity gain code for a given number of ramp bits.
    function automatic int unsigned full_gain(input int unsigned ramp_bits);
        return 32'd1 << ramp_bits;
    endfunction

endpackage

// File: rtl/audio_gain_stage.sv
// Signed sample scaling: (sample * gain) >>> RAMP_BITS, floor rounding.
module audio_gain_stage #(
    parameter int DATA_W    = 24,
    parameter int RAMP_BITS = 6
) (
    input  logic [DATA_W-1:0]  i_sample,
    input  logic [RAMP_BITS:0] i_gain,
    output logic [DATA_W-1:0]  o_scaled
);

    // gain never exceeds 2^RAMP_BITS, so the product fits in DATA_W+RAMP_BITS bits
    localparam int PROD_W = DATA_W + RAMP_BITS;

    logic signed [PROD_W-1:0] w_a;
    logic signed [PROD_W-1:0] w_b;
    logic signed [PROD_W-1:0] w_prod;
    logic                     w_unused_lsb;

    assign w_a    = {{RAMP_BITS{i_sample[DATA_W-1]}}, i_sample};
    assign w_b    = {{(DATA_W-1){1'b0}}, i_gain};
    assign w_prod = w_a * w_b;

    // dropping the low bits of a two's complement value is a floor divide
    assign o_scaled     = w_prod[RAMP_BITS +: DATA_W];
    assign w_unused_lsb = ^w_prod[RAMP_BITS-1:0];

endmodule

// File: rtl/audio_stream_router.sv
// Routes one of NUM_SRC stereo sources to the output with click-free
// gain ramps on source change, mute and run enable.
//
//   state        | meaning
//   ST_PASS      | routed at full gain
//   ST_RAMP_DOWN | fading out, one step per frame tick
//   ST_SWAP      | one clk, latch new source, outputs invalid
//   ST_RAMP_UP   | fading in, one step per frame tick
//   ST_MUTED     | gain 0, strobes forwarded with zero data
module audio_stream_router
    import audio_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = 24,
    parameter int RAMP_BITS = 6,
    parameter int SEL_W     = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic                      mute,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic [NUM_SRC-1:0]        src_l_valid,
    input  logic [NUM_SRC-1:0]        src_r_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_l_data,
    input  logic [NUM_SRC*DATA_W-1:0] src_r_data,
    output logic                      l_valid,
    output logic                      r_valid,
    output logic [DATA_W-1:0]         l_data,
    output logic [DATA_W-1:0]         r_data,
    output logic [SEL_W-1:0]          cur_sel,
    output logic [RAMP_BITS:0]        gain,
    output logic                      busy
);

    localparam logic [RAMP_BITS:0] FULL      = (RAMP_BITS+1)'(full_gain(RAMP_BITS));
    localparam logic [RAMP_BITS:0] GAIN_ONE  = (RAMP_BITS+1)'(1);
    localparam logic [SEL_W:0]     SRC_LIMIT = (SEL_W+1)'(NUM_SRC);

    router_state_t     r_state;
    router_state_t     w_state_nxt;
    logic [SEL_W-1:0]  r_cur_sel;
    logic [SEL_W-1:0]  w_cur_sel_nxt;
    logic [RAMP_BITS:0] r_gain;
    logic [RAMP_BITS:0] w_gain_nxt;

    logic              r_l_valid;
    logic              r_r_valid;
    logic [DATA_W-1:0] r_l_data;
    logic [DATA_W-1:0] r_r_data;

    logic              w_l_strobe;
    logic              w_r_strobe;
    logic [DATA_W-1:0] w_l_sample;
    logic [DATA_W-1:0] w_r_sample;
    logic [DATA_W-1:0] w_l_scaled;
    logic [DATA_W-1:0] w_r_scaled;
    logic              w_tick;
    logic              w_sel_in_range;
    logic              w_sel_same;
    logic [SEL_W-1:0]  w_sel_eff;
    logic              w_out_en;

    // Select strobes and samples of the currently routed source.
    always_comb begin
        w_l_strobe = 1'b0;
        w_r_strobe = 1'b0;
        w_l_sample = '0;
        w_r_sample = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (r_cur_sel == SEL_W'(k)) begin
                w_l_strobe = src_l_valid[k];
                w_r_strobe = src_r_valid[k];
                w_l_sample = src_l_data[k*DATA_W +: DATA_W];
                w_r_sample = src_r_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Right-channel strobe of the routed source marks a frame.
    assign w_tick = w_r_strobe;

    // Out-of-range requests behave as "keep the current source".
    assign w_sel_in_range = {1'b0, src_sel} < SRC_LIMIT;
    assign w_sel_same     = !w_sel_in_range || (src_sel == r_cur_sel);
    assign w_sel_eff      = w_sel_in_range ? src_sel : r_cur_sel;

    // Next-state, gain and source selection; transitions look at the
    // registered gain so a same-clk tick lands before the decision.
    always_comb begin
        w_state_nxt   = r_state;
        w_gain_nxt    = r_gain;
        w_cur_sel_nxt = r_cur_sel;
        case (r_state)
            ST_PASS: begin
                w_gain_nxt = FULL;
                if (mute || !w_sel_same) w_state_nxt = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
                if (w_tick && (r_gain != '0)) w_gain_nxt = r_gain - GAIN_ONE;
                if (!mute && w_sel_same)      w_state_nxt = ST_RAMP_UP;
                else if (r_gain == '0)        w_state_nxt = mute ? ST_MUTED : ST_SWAP;
            end
            ST_SWAP: begin
                w_gain_nxt    = '0;
                w_cur_sel_nxt = w_sel_eff;
                w_state_nxt   = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (w_tick && (r_gain != FULL)) w_gain_nxt = r_gain + GAIN_ONE;
                if (mute || !w_sel_same)        w_state_nxt = ST_RAMP_DOWN;
                else if (r_gain == FULL)        w_state_nxt = ST_PASS;
            end
            ST_MUTED: begin
                w_gain_nxt = '0;
                if (!mute) w_state_nxt = w_sel_same ? ST_RAMP_UP : ST_SWAP;
            end
            default: begin
                w_state_nxt = ST_MUTED;
                w_gain_nxt  = '0;
            end
        endcase
        if (!run) begin
            w_state_nxt   = ST_MUTED;
            w_gain_nxt    = '0;
            w_cur_sel_nxt = r_cur_sel;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_MUTED;
            r_cur_sel <= '0;
            r_gain    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_sel <= w_cur_sel_nxt;
            r_gain    <= w_gain_nxt;
        end
    end

    audio_gain_stage #(.DATA_W(DATA_W), .RAMP_BITS(RAMP_BITS)) u_gain_l (
        .i_sample (w_l_sample),
        .i_gain   (r_gain),
        .o_scaled (w_l_scaled)
    );

    audio_gain_stage #(.DATA_W(DATA_W), .RAMP_BITS(RAMP_BITS)) u_gain_r (
        .i_sample (w_r_sample),
        .i_gain   (r_gain),
        .o_scaled (w_r_scaled)
    );

    assign w_out_en = run && (r_state != ST_SWAP);

    // Output registers: one clk from source strobe, zero data when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_l_valid <= 1'b0;
            r_r_valid <= 1'b0;
            r_l_data  <= '0;
            r_r_data  <= '0;
        end else begin
            r_l_valid <= w_l_strobe && w_out_en;
            r_r_valid <= w_r_strobe && w_out_en;
            r_l_data  <= (w_l_strobe && w_out_en) ? w_l_scaled : '0;
            r_r_data  <= (w_r_strobe && w_out_en) ? w_r_scaled : '0;
        end
    end

    assign l_valid = r_l_valid;
    assign r_valid = r_r_valid;
    assign l_data  = r_l_data;
    assign r_data  = r_r_data;
    assign cur_sel = r_cur_sel;
    assign gain    = r_gain;
    assign busy    = (r_state == ST_RAMP_DOWN) || (r_state == ST_SWAP) ||
                     (r_state == ST_RAMP_UP);

endmodule

// File: tb/tb_audio_stream_router.sv
// Randomized and directed bench for audio_stream_router against a
// gain-seeking reference model.
module tb_audio_stream_router;

    localparam int NS   = 4;
    localparam int DW   = 24;
    localparam int RB   = 4;
    localparam int SW   = 3;
    localparam int FULL = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            run;
    logic            mute;
    logic [SW-1:0]   src_sel;
    logic [NS-1:0]   lv;
    logic [NS-1:0]   rv;
    logic [NS*DW-1:0] ld;
    logic [NS*DW-1:0] rd;
    logic            l_valid;
    logic            r_valid;
    logic [DW-1:0]   l_data;
    logic [DW-1:0]   r_data;
    logic [SW-1:0]   cur_sel;
    logic [RB:0]     gain;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    // model: gain, routed source, direction (-1 fading, +1 rising, 0 at rest), swap clk pending
    int m_gain = 0;
    int m_cur  = 0;
    int m_dir  = 0;
    bit m_swap = 1'b0;

    audio_stream_router #(
        .NUM_SRC(NS), .DATA_W(DW), .RAMP_BITS(RB), .SEL_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .mute(mute), .src_sel(src_sel),
        .src_l_valid(lv), .src_r_valid(rv), .src_l_data(ld), .src_r_data(rd),
        .l_valid(l_valid), .r_valid(r_valid), .l_data(l_data), .r_data(r_data),
        .cur_sel(cur_sel), .gain(gain), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] scale(input logic [DW-1:0] s, input int g);
        int sv, p, q;
        sv = int'($signed(s));
        p  = sv * g;
        q  = p / FULL;
        if (p < 0 && (p % FULL) != 0) q = q - 1;
        return q[DW-1:0];
    endfunction

    // One clk: predict from pre-edge inputs/model, then compare after the edge.
    task automatic cycle();
        int sel_i, n_gain, n_cur, n_dir;
        bit in_rng, other, go_low, tick, out_ok, e_lv, e_rv, n_swap;
        logic [DW-1:0] e_ld, e_rd;
        sel_i  = int'(src_sel);
        in_rng = sel_i < NS;
        other  = in_rng && (sel_i != m_cur);
        go_low = mute || other;
        tick   = rv[m_cur];
        out_ok = run && !m_swap;
        e_lv   = out_ok && lv[m_cur];
        e_rv   = out_ok && rv[m_cur];
        e_ld   = e_lv ? scale(ld[m_cur*DW +: DW], m_gain) : '0;
        e_rd   = e_rv ? scale(rd[m_cur*DW +: DW], m_gain) : '0;
        n_gain = m_gain; n_cur = m_cur; n_dir = m_dir; n_swap = m_swap;
        if (!run) begin
            n_gain = 0; n_dir = 0; n_swap = 0;
        end else if (m_swap) begin
            n_cur = in_rng ? sel_i : m_cur; n_swap = 0; n_dir = 1; n_gain = 0;
        end else if (m_dir == 0 && m_gain == FULL) begin
            if (go_low) n_dir = -1;
        end else if (m_dir == 0) begin
            if (!mute) begin
                if (other) n_swap = 1; else n_dir = 1;
            end
        end else if (m_dir < 0) begin
            if (tick && m_gain > 0) n_gain = m_gain - 1;
            if (!go_low) n_dir = 1;
            else if (m_gain == 0) begin n_dir = 0; n_swap = !mute; end
        end else begin
            if (tick && m_gain < FULL) n_gain = m_gain + 1;
            if (go_low) n_dir = -1;
            else if (m_gain == FULL) n_dir = 0;
        end
        @(posedge clk);
        #1;
        m_gain = n_gain; m_cur = n_cur; m_dir = n_dir; m_swap = n_swap;
        check_eq("l_valid", l_valid, e_lv);
        check_eq("r_valid", r_valid, e_rv);
        check_eq("l_data", l_data, e_ld);
        check_eq("r_data", r_data, e_rd);
        check_eq("gain", gain, m_gain);
        check_eq("cur_sel", cur_sel, m_cur);
        check_eq("busy", busy, m_swap || (m_dir != 0));
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_l_valid", l_valid, 0);
        check_eq("rst_r_valid", r_valid, 0);
        check_eq("rst_l_data", l_data, 0);
        check_eq("rst_r_data", r_data, 0);
        check_eq("rst_gain", gain, 0);
        check_eq("rst_cur_sel", cur_sel, 0);
        check_eq("rst_busy", busy, 0);
        m_gain = 0; m_cur = 0; m_dir = 0; m_swap = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int min_g;
        run = 1'b0; mute = 1'b0; src_sel = '0;
        lv = '0; rv = '0; ld = '0; rd = '0;
        @(negedge clk);
        apply_reset();

        // ramp up from reset-muted to PASS on source 0
        run = 1'b1; rv = '1;
        for (int i = 0; i < 40 && busy !== 1'b0 || i == 0; i++) cycle();
        for (int i = 0; i < 40 && gain != FULL; i++) cycle();
        if (busy) cycle();
        check_eq("up_full_gain", gain, FULL);
        check_eq("up_full_busy", busy, 0);

        // passthrough and ignored strobes
        rv = '0; lv = 4'b0001; ld[23:0] = 24'h123456;
        cycle();
        check_eq("pass_data", l_data, 24'h123456);
        check_eq("pass_valid", l_valid, 1);
        lv = 4'b0010; ld[47:24] = 24'h654321;
        cycle();
        check_eq("other_src_valid", l_valid, 0);

        // source switch 0 -> 2 with a tick every clk
        src_sel = 3'd2; rv = 4'b0101; lv = '0; n = 0;
        for (int i = 0; i < 80; i++) begin
            cycle(); n++;
            if (!busy && cur_sel == 3'd2) break;
        end
        check_eq("switch_cycles", n, 36);
        check_eq("switch_gain", gain, FULL);

        // mute, zero-data strobes while muted, then gain arithmetic at 8
        mute = 1'b1; rv = 4'b0100;
        for (int i = 0; i < 60 && (gain != 0 || busy); i++) cycle();
        rv = '0; lv = 4'b0100; ld[71:48] = 24'h7FFFFF;
        cycle();
        check_eq("muted_valid", l_valid, 1);
        check_eq("muted_data", l_data, 0);
        mute = 1'b0; lv = '0; rv = 4'b0100;
        for (int i = 0; i < 40 && gain != 8; i++) cycle();
        rv = '0; lv = 4'b0100; ld[71:48] = 24'hFFFFFD;
        cycle();
        check_eq("gain8_neg3", l_data, 24'hFFFFFE);
        ld[71:48] = 24'h000007;
        cycle();
        check_eq("gain8_pos7", l_data, 24'h000003);
        lv = '0; rv = 4'b0100;
        for (int i = 0; i < 40 && busy; i++) cycle();
        check_eq("unmute_gain", gain, FULL);

        // reversal at gain 10: back to the current source, no swap
        src_sel = 3'd1;
        for (int i = 0; i < 40 && gain != 10; i++) cycle();
        src_sel = 3'd2; rv = '0;
        cycle();
        check_eq("rev_gain", gain, 10);
        check_eq("rev_busy", busy, 1);
        rv = 4'b0100; min_g = FULL;
        for (int i = 0; i < 40 && busy; i++) begin
            cycle();
            if (int'(gain) < min_g) min_g = int'(gain);
        end
        check_eq("rev_no_swap", min_g >= 10, 1);
        check_eq("rev_cur_sel", cur_sel, 2);

        // out-of-range selection is ignored
        src_sel = 3'd7; rv = '1;
        for (int i = 0; i < 5; i++) cycle();
        check_eq("sel7_busy", busy, 0);
        check_eq("sel7_cur", cur_sel, 2);

        // reset in the middle of a ramp
        src_sel = 3'd0; lv = '1;
        for (int i = 0; i < 40 && gain != 5; i++) cycle();
        check_eq("pre_rst_gain", gain, 5);
        apply_reset();

        // run low: no strobes reach the output
        run = 1'b0; lv = '1; rv = '1;
        for (int i = 0; i < 5; i++) cycle();
        check_eq("run0_valid", l_valid | r_valid, 0);
        run = 1'b1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            lv = NS'($urandom);
            rv = NS'($urandom);
            ld = {$urandom, $urandom, $urandom};
            rd = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 59) == 0) src_sel = SW'($urandom_range(0, 7));
            if ($urandom_range(0, 79) == 0) mute = !mute;
            if (run ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 9) == 0)) run = !run;
            if ($urandom_range(0, 999) == 0) apply_reset();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/audio_stream_router.md
AUDIO_STREAM_ROUTER -- requirements
Module: audio_stream_router

Interface
REQ-001 Parameters SHALL be:
  - NUM_SRC, default 4, number of stereo sources.
  - DATA_W, default 24, signed PCM sample width.
  - RAMP_BITS, default 6, log2 of ramp steps; gain is unsigned RAMP_BITS+1 bits.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk  in  1  single system clock; all logic is on its rising edge.
  - reset  in  1  asynchronous, active-high reset.
  - run  in  1  audio enable.
  - mute  in  1  request a soft mute.
  - src_sel  in  $clog2(NUM_SRC)  requested source.
  - src_l_valid, src_r_valid  in  NUM_SRC  per-source sample strobes.
  - src_l_data, src_r_data  in  NUM_SRC*DATA_W  packed samples; source k occupies [k*DATA_W +: DATA_W].
  - l_valid, r_valid  out  1  output strobes.
  - l_data, r_data  out  DATA_W  output samples.
  - cur_sel  out  $clog2(NUM_SRC)  source currently routed.
  - gain  out  RAMP_BITS+1  current gain.
  - busy  out  1  high in any ramp or swap state.

Function
REQ-003 The block SHALL route one source at a time to the output. The output SHALL be (sample * gain) >>> RAMP_BITS, computed as signed, truncated toward minus infinity, and result width DATA_W.
REQ-004 When gain = 2^RAMP_BITS (FULL), the output SHALL equal the input bit-exactly. When gain = 0, the output SHALL be 0.
REQ-005 Latency SHALL be exactly 1 clk from src_x_valid[cur_sel] to x_valid, with x_data registered on the same edge. Strobes from non-selected sources SHALL be ignored.
REQ-006 The FSM SHALL have states PASS, RAMP_DOWN, SWAP, RAMP_UP and MUTED.
REQ-007 A frame tick SHALL be src_r_valid[cur_sel]. Gain SHALL change by exactly 1 per frame tick, and only in RAMP_DOWN or RAMP_UP.
REQ-008 PASS: gain = FULL. The FSM SHALL go to RAMP_DOWN when src_sel != cur_sel (and src_sel < NUM_SRC), or when mute = 1.
REQ-009 RAMP_DOWN: gain decrements per tick. On reaching 0, the FSM SHALL go to MUTED if mute = 1, otherwise to SWAP. If mute = 0 and src_sel == cur_sel, it SHALL go to RAMP_UP from the current gain.
REQ-010 SWAP SHALL last 1 clk. In it: cur_sel <= src_sel, gain stays 0, outputs stay invalid; next state is RAMP_UP.
REQ-011 RAMP_UP: gain increments per tick. On reaching FULL, the FSM SHALL go to PASS. If mute = 1 or src_sel != cur_sel, it SHALL go to RAMP_DOWN from the current gain.
REQ-012 MUTED: gain = 0 and valid strobes still pass, with data 0. When mute = 0, the FSM SHALL go to SWAP if src_sel != cur_sel, otherwise to RAMP_UP.
REQ-013 src_sel >= NUM_SRC SHALL be ignored and treated as equal to cur_sel.
REQ-014 If a frame tick and a state transition occur in the same clk, the gain update SHALL apply first. Transition conditions SHALL be evaluated on the updated gain in the next clk.
REQ-015 When run = 0: state <= MUTED-equivalent hold with gain = 0, outputs valid = 0, data = 0. On run rising, the FSM SHALL go to RAMP_UP from gain 0 (SWAP first if src_sel != cur_sel).
REQ-016 The gain counter SHALL saturate at 0 and FULL; it SHALL never wrap.

Reset
REQ-017 On reset, the block SHALL asynchronously set: state = MUTED, cur_sel = 0, gain = 0, l_valid = r_valid = 0, l_data = r_data = 0, busy = 0.
REQ-018 After reset is released, operation SHALL follow REQ-012/015. Reset asserted mid-ramp SHALL abort the ramp with no residual output strobe.

Structure
REQ-019 Shared package audio_pkg SHALL hold the FSM state typedef (router_state_t) and the function computing RAMP_BITS-dependent FULL.
REQ-020 The signed multiply/shift SHALL be one sub-module, audio_gain_stage (DATA_W, RAMP_BITS), instantiated once per channel (l, r).

Verification
REQ-021 Directed scenarios (RAMP_BITS = 4, DATA_W = 24, NUM_SRC = 4):
  - Passthrough: PASS, src 0 delivers l = 24'h123456 → l_data = 24'h123456 one clk later; src 1 strobes produce no output.
  - Switch: src_sel 0→2 → gain steps 16..0 over 16 r ticks, one SWAP clk, cur_sel = 2, gain steps 0..16 over 16 ticks, then busy = 0.
  - Gain arithmetic: gain = 8, input −3 (24'hFFFFFD) → output −2 (24'hFFFFFE); input 7 → 3.
  - Reversal: src_sel 0→1 then back to 0 at gain = 10 → RAMP_UP from 10, cur_sel stays 0, no SWAP.
  - Mute: mute = 1 in PASS → gain reaches 0, MUTED, valids continue with data 0; mute = 0 → RAMP_UP to 16.
  - Reset/run: reset asserted at gain = 5 → all outputs 0 immediately; run = 0 → no valids; src_sel = 7 (NUM_SRC = 4 with a 3-bit test override) → ignored.
